rst_seq_gen: RTL
================

# rst_seq_gen

Parametrised reset sequencer that releases `N_OUT` synchronous active-low reset outputs one after another after a common hold period. It also supports software-triggered partial re-reset of a selected subset of outputs. It sits directly behind `clkgen_xil7series` in the FPGA top and supersedes the single-output `reset_generator`. Each output feeds one domain (e.g. `alg_core`, peripherals, CPU) so that block ordering at start-up is deterministic.

## Interface
- `N_OUT`, 4: number of reset outputs, ≥1.
- `HOLD_CYCLES`, 16: cycles all selected outputs stay asserted before the first release, ≥1.
- `STEP_CYCLES`, 8: spacing in cycles between consecutive release slots, ≥1.
- `clk` input 1: system clock.
- `rst_n` input 1: reset, synchronous, active-low. One clock; all state is sampled on the rising edge of `clk`.
- `trigger` input 1: soft-reset request, synchronous to `clk`; acts on its rising edge.
- `trigger_sel` input `N_OUT`: outputs to re-reset on a trigger edge. It is sampled only on the trigger edge.
- `rst_n_out` output `N_OUT`: sequenced resets, active-low, registered.
- `busy` output 1: high while a sequence is in progress.
- `done` output 1: one-cycle pulse when a sequence completes.

## Operation
- States: `HOLD`, `RELEASE`, `RUN`.
- Registers:
  - `mask[N_OUT]`: outputs participating in the current sequence.
  - `cnt`: width `$clog2(max(HOLD_CYCLES,STEP_CYCLES)+1)`.
  - `idx`: width `$clog2(N_OUT+1)`.
  - `trig_q`: previous value of `trigger`.
- Reset (`rst_n`=0): state=`HOLD`, cnt=0, idx=0, mask=all ones, `trig_q`=0, `rst_n_out`=0, `busy`=1, `done`=0.
- `HOLD`: cnt counts up. When cnt reaches HOLD_CYCLES−1: release slot 0, idx=1, cnt=0, go to `RELEASE`. If N_OUT=1, go to `RUN` instead.
- `RELEASE`: cnt counts to STEP_CYCLES−1, then releases slot idx and increments idx. Releasing the slot for index N_OUT−1 goes to `RUN`.
- Release of slot i sets `rst_n_out[i]`=1 only if `mask[i]`=1. Slots not in mask are still consumed, so timing is independent of the mask.
- `RUN`: `busy`=0 and outputs are stable. `done`=1 for exactly the cycle in which the last slot is released. `busy` falls on that same edge.
- Trigger edge: `trigger`=1 and `trig_q`=0, and `trigger_sel`≠0, in any state.
  - Set mask = `trigger_sel` | pending, where pending = outputs currently still 0.
  - Drive the masked outputs to 0. Unmasked outputs keep their value.
  - Set state=`HOLD`, cnt=0, idx=0, `busy`=1.
- A trigger edge with `trigger_sel`=0 is ignored; no state change.
- A held-high `trigger` yields exactly one sequence.
- `rst_n`=0 mid-sequence overrides everything and forces the reset values.

## Timing
- Cycle 0 is the first edge sampling `rst_n`=1.
- `rst_n_out[i]` rises at edge HOLD_CYCLES + i·STEP_CYCLES. The `done` pulse and the `busy` fall both occur at edge HOLD_CYCLES + (N_OUT−1)·STEP_CYCLES.
- For a trigger edge sampled at edge t, masked outputs fall at edge t. Output i rises at t + HOLD_CYCLES + i·STEP_CYCLES.
- All outputs are registered, with zero combinational paths from inputs to outputs.

## Structure
- Package `rst_seq_pkg`: state enum `rst_seq_state_t` {`HOLD`,`RELEASE`,`RUN`}.
- One sub-module `rise_edge_det`: registered rising-edge detector on `trigger` with synchronous active-low reset. It holds `trig_q`.
- The top-level FPGA wrapper ANDs each `rst_n_out[i]` into its target domain. `rst_n` comes from `rst_sys_n` of the clock generator.

## Test plan
All scenarios use N_OUT=4, HOLD_CYCLES=16, STEP_CYCLES=8.
- Power-on: `rst_n`=0 for 5 cycles, then 1 → outputs 0 during reset, `busy`=1. `rst_n_out` bits 0/1/2/3 rise at edges 16/24/32/40. `done` pulses at 40 only; `busy`=0 from 40.
- Partial trigger in `RUN`: `trigger_sel`=4'b0100, edge at t → only bit 2 falls at t and rises at t+32. Other bits stay 1. `done` fires at t+40.
- Level trigger: `trigger` held 1 for 100 cycles with sel=4'b0001 → exactly one `done`. Bit 0 falls once at the edge and rises at edge+16.
- Null trigger: edge with `trigger_sel`=0 in `RUN` → no output change, `busy` stays 0, no `done`.
- Re-trigger mid-sequence: at power-on edge 30 (bits 0,1 released), trigger with sel=4'b0001 → mask=4'b1101. Bit 0 falls at 30; bit 1 stays 1. Bits 0/2/3 rise at 46/62/70, with `done` at 70.
- Reset mid-sequence: `rst_n`=0 at edge 35 → all outputs 0 and `busy`=1 at 35. Release `rst_n` → the sequence restarts from cycle 0 with full mask.

Source files
------------

// File: rtl/rst_seq_gen_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and a small sizing helper.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN
    } rst_seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Registered rising-edge detector; trig_q holds the previous input sample.
module rise_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic trig_q;

    always_ff @(posedge clk) begin
        if (!rst_n) trig_q <= 1'b0;
        else        trig_q <= d;
    end

    assign rise = d & ~trig_q;

endmodule

// File: rtl/rst_seq_gen.sv
// Releases N_OUT active-low resets one slot at a time after a common hold period,
// with software-triggered partial re-reset of a selected subset.
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int N_OUT       = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trigger,
    input  logic [N_OUT-1:0] trigger_sel,
    output logic [N_OUT-1:0] rst_n_out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STEP_CYCLES) + 1);
    localparam int IDX_W = $clog2(N_OUT + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_OUT - 1);

    rst_seq_state_t   state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [N_OUT-1:0] mask;
    logic             started;
    logic             trig_rise;
    logic             trig_go;

    rise_edge_det u_trig_det (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (trigger),
        .rise  (trig_rise)
    );

    assign trig_go = trig_rise & (|trigger_sel);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HOLD;
            cnt       <= '0;
            idx       <= '0;
            mask      <= '1;
            started   <= 1'b0;
            rst_n_out <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (trig_go) begin
                // Outputs still held low stay in the sequence so they get released too.
                mask      <= trigger_sel | ~rst_n_out;
                rst_n_out <= rst_n_out & ~trigger_sel;
                state     <= HOLD;
                cnt       <= '0;
                idx       <= '0;
                busy      <= 1'b1;
                started   <= 1'b1;
            end else begin
                case (state)
                    HOLD: begin
                        // First cycle out of reset plays the role of the trigger edge,
                        // so power-on and soft-reset share the same release timing.
                        if (!started) begin
                            started <= 1'b1;
                        end else if (cnt == HOLD_LAST) begin
                            if (mask[0]) rst_n_out[0] <= 1'b1;
                            cnt <= '0;
                            idx <= IDX_W'(1);
                            if (N_OUT == 1) begin
                                state <= RUN;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= RELEASE;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    RELEASE: begin
                        if (cnt == STEP_LAST) begin
                            for (int i = 0; i < N_OUT; i++) begin
                                if (IDX_W'(i) == idx && mask[i]) rst_n_out[i] <= 1'b1;
                            end
                            cnt <= '0;
                            idx <= idx + IDX_W'(1);
                            if (idx == IDX_LAST) begin
                                state <= RUN;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    RUN: ;
                    default: state <= HOLD;
                endcase
            end
        end
    end

endmodule
